// File: rtl/nios2_debug_slave_cmd_fifo.sv
// System-clock side of the Nios II debug-slave JTAG bridge: resynchronises update-DR toggles, queues
// {ir_in, sr} in a command FIFO and dispatches one-cycle action pulses. Optional macro: DBG_CMD_PARITY_EN.
module nios2_debug_slave_cmd_fifo #(
  parameter int DATA_WIDTH  = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = 35
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            udr_toggle,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [DATA_WIDTH-1:0]           sr,
  input  logic                            cmd_ready,
  input  logic                            err_clr,
  output logic                            cmd_valid,
  output logic [IR_WIDTH-1:0]             head_ir,
  output logic [DATA_WIDTH-1:0]           jdo,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            parity_err
);

  localparam int NUM_ACT = 2**IR_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int WORD_W  = IR_WIDTH + DATA_WIDTH;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   armed_r;
  logic [ARM_W-1:0]       arm_cnt_r;
  logic                   edge_s;

  logic [WORD_W-1:0]      mem_r [FIFO_DEPTH];
  logic [LVL_W-1:0]       wr_cnt_r, rd_cnt_r;
  logic [LVL_W-1:0]       wr_cnt_nxt_s, rd_cnt_nxt_s, level_s, level_nxt_s;
  logic                   full_s, empty_s, pop_s, push_s, ovf_set_s, par_set_s, parity_ok_s;
  logic [WORD_W-1:0]      head_word_s, next_word_s;
  logic [IR_WIDTH-1:0]    head_ir_s, next_head_ir_s;
  logic [NUM_ACT-1:0]     act_nxt_s, nact_nxt_s;

  logic                   cmd_valid_r;
  logic [IR_WIDTH-1:0]    head_ir_r;
  logic [DATA_WIDTH-1:0]  jdo_r;
  logic [NUM_ACT-1:0]     take_action_r, take_no_action_r;
  logic [LVL_W-1:0]       fifo_level_r;
  logic                   overflow_r, parity_err_r;

`ifdef DBG_CMD_PARITY_EN
  function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] d);
    return ~(^d);
  endfunction
  assign parity_ok_s = even_parity_ok(sr);
  assign par_set_s   = edge_s & ~parity_ok_s;
`else
  assign parity_ok_s = 1'b1;
  assign par_set_s   = 1'b0;
`endif

  // Toggle synchroniser; edge detection stays disarmed until the chain has settled after reset,
  // so a toggle level already high at reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r    <= {SYNC_STAGES{1'b0}};
      prev_r    <= 1'b0;
      armed_r   <= 1'b0;
      arm_cnt_r <= {ARM_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], udr_toggle};
      prev_r <= sync_r[SYNC_STAGES-1];
      if (!armed_r) begin
        arm_cnt_r <= arm_cnt_r + ARM_W'(1);
        armed_r   <= (arm_cnt_r == ARM_LAST);
      end else begin
        arm_cnt_r <= arm_cnt_r;
        armed_r   <= 1'b1;
      end
    end
  end

  assign edge_s = armed_r & (sync_r[SYNC_STAGES-1] ^ prev_r);

  // FIFO control, next-head lookahead and dispatch pulse decode.
  always_comb begin
    level_s      = wr_cnt_r - rd_cnt_r;
    full_s       = (level_s == FULL_LVL);
    empty_s      = (level_s == {LVL_W{1'b0}});
    pop_s        = ~empty_s & cmd_ready;
    push_s       = edge_s & parity_ok_s & (~full_s | pop_s);
    ovf_set_s    = edge_s & parity_ok_s & full_s & ~pop_s;
    head_word_s  = mem_r[rd_cnt_r[PTR_W-1:0]];
    head_ir_s    = head_word_s[WORD_W-1:DATA_WIDTH];
    wr_cnt_nxt_s = push_s ? (wr_cnt_r + LVL_W'(1)) : wr_cnt_r;
    rd_cnt_nxt_s = pop_s  ? (rd_cnt_r + LVL_W'(1)) : rd_cnt_r;
    level_nxt_s  = wr_cnt_nxt_s - rd_cnt_nxt_s;
    next_word_s  = mem_r[rd_cnt_nxt_s[PTR_W-1:0]];
    // The word being pushed becomes the head when the FIFO drains to exactly that word.
    if (level_nxt_s == {LVL_W{1'b0}}) begin
      next_head_ir_s = {IR_WIDTH{1'b0}};
    end else if (push_s && (wr_cnt_r[PTR_W-1:0] == rd_cnt_nxt_s[PTR_W-1:0])) begin
      next_head_ir_s = ir_in;
    end else begin
      next_head_ir_s = next_word_s[WORD_W-1:DATA_WIDTH];
    end
    act_nxt_s  = {NUM_ACT{1'b0}};
    nact_nxt_s = {NUM_ACT{1'b0}};
    if (pop_s) begin
      act_nxt_s[head_ir_s]  = head_word_s[ACT_BIT];
      nact_nxt_s[head_ir_s] = ~head_word_s[ACT_BIT];
    end else begin
      act_nxt_s  = {NUM_ACT{1'b0}};
      nact_nxt_s = {NUM_ACT{1'b0}};
    end
  end

  // Command storage; emptiness is tracked by the counters, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_cnt_r[PTR_W-1:0]] <= {ir_in, sr};
    end
  end

  // Pointers, registered status outputs and dispatch pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_r         <= {LVL_W{1'b0}};
      rd_cnt_r         <= {LVL_W{1'b0}};
      cmd_valid_r      <= 1'b0;
      head_ir_r        <= {IR_WIDTH{1'b0}};
      fifo_level_r     <= {LVL_W{1'b0}};
      jdo_r            <= {DATA_WIDTH{1'b0}};
      take_action_r    <= {NUM_ACT{1'b0}};
      take_no_action_r <= {NUM_ACT{1'b0}};
    end else begin
      wr_cnt_r         <= wr_cnt_nxt_s;
      rd_cnt_r         <= rd_cnt_nxt_s;
      cmd_valid_r      <= (level_nxt_s != {LVL_W{1'b0}});
      head_ir_r        <= next_head_ir_s;
      fifo_level_r     <= level_nxt_s;
      take_action_r    <= act_nxt_s;
      take_no_action_r <= nact_nxt_s;
      if (pop_s) begin
        jdo_r <= head_word_s[DATA_WIDTH-1:0];
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r   <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end
      if (par_set_s) begin
        parity_err_r <= 1'b1;
      end else if (err_clr) begin
        parity_err_r <= 1'b0;
      end
    end
  end

  assign cmd_valid      = cmd_valid_r;
  assign head_ir        = head_ir_r;
  assign jdo            = jdo_r;
  assign take_action    = take_action_r;
  assign take_no_action = take_no_action_r;
  assign fifo_level     = fifo_level_r;
  assign overflow       = overflow_r;
  assign parity_err     = parity_err_r;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_fifo.sv
// Directed testbench for nios2_debug_slave_cmd_fifo (default parameters, DEPTH=4, 3 sync stages).
module tb_nios2_debug_slave_cmd_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        udr_toggle;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        err_clr;
  logic        cmd_valid;
  logic [1:0]  head_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        parity_err;

  int n_vec = 0;
  int n_err = 0;
  logic tog = 1'b0;

  nios2_debug_slave_cmd_fifo dut (
    .clk(clk), .reset(reset), .udr_toggle(udr_toggle), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .err_clr(err_clr), .cmd_valid(cmd_valid), .head_ir(head_ir),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and flip the toggle; the push lands on the 4th following clock edge.
  task automatic push_word(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir;
    sr = d;
    tog = ~tog;
    udr_toggle = tog;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; udr_toggle = 1'b1; tog = 1'b1;
    ir_in = 2'd0; sr = 38'h0; cmd_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    n_vec++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fifo level=%0d valid=%b exp 0/0", fifo_level, cmd_valid); end
    n_vec++; if (take_action !== 4'h0 || take_no_action !== 4'h0) begin n_err++; $display("FAIL reset_pulses act=%b nact=%b exp 0", take_action, take_no_action); end
    n_vec++; if (jdo !== 38'h0 || overflow !== 1'b0 || parity_err !== 1'b0 || head_ir !== 2'd0) begin n_err++; $display("FAIL reset_regs jdo=%h ovf=%b perr=%b hir=%0d exp 0", jdo, overflow, parity_err, head_ir); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_vec++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL arm_no_push cyc=%0d level=%0d valid=%b exp 0/0", i, fifo_level, cmd_valid); end
    end
  endtask

  task automatic test_single();
    cmd_ready = 1'b1;
    ir_in = 2'd2; sr = 38'h2A_1234_5678;
    tog = ~tog; udr_toggle = tog;
    repeat (3) step();
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL single_early level=%0d exp 0", fifo_level); end
    step();
    n_vec++; if (fifo_level !== 3'd1 || cmd_valid !== 1'b1 || head_ir !== 2'd2) begin n_err++; $display("FAIL single_push level=%0d valid=%b hir=%0d exp 1/1/2", fifo_level, cmd_valid, head_ir); end
    step();
    n_vec++; if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin n_err++; $display("FAIL single_pulse act=%b nact=%b exp 0100/0000", take_action, take_no_action); end
    n_vec++; if (jdo !== 38'h2A_1234_5678 || fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_jdo jdo=%h level=%0d exp 2a12345678/0", jdo, fifo_level); end
    step();
    n_vec++; if (take_action !== 4'b0000 || jdo !== 38'h2A_1234_5678) begin n_err++; $display("FAIL single_hold act=%b jdo=%h exp 0000/2a12345678", take_action, jdo); end
  endtask

  task automatic test_overflow_drain();
    logic [37:0] ow [6];
    logic [3:0] one;
    cmd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ow[k] = 38'h00_0000_1000 + 38'(k);
      if (k % 2 == 1) ow[k][35] = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      push_word(2'(k), ow[k]);
      n_vec++; if (fifo_level !== 3'((k < 4) ? k + 1 : 4) || overflow !== ((k >= 4) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL fill_%0d level=%0d ovf=%b exp %0d/%0d", k, fifo_level, overflow, (k < 4) ? k + 1 : 4, (k >= 4) ? 1 : 0);
      end
    end
    n_vec++; if (head_ir !== 2'd0 || cmd_valid !== 1'b1) begin n_err++; $display("FAIL full_head hir=%0d valid=%b exp 0/1", head_ir, cmd_valid); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      one = 4'b0001 << i;
      n_vec++; if (jdo !== ow[i] || take_action !== ((i % 2 == 1) ? one : 4'b0000) || take_no_action !== ((i % 2 == 1) ? 4'b0000 : one)) begin
        n_err++; $display("FAIL drain_%0d jdo=%h act=%b nact=%b exp jdo=%h one=%b", i, jdo, take_action, take_no_action, ow[i], one);
      end
    end
    n_vec++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty level=%0d valid=%b exp 0/0", fifo_level, cmd_valid); end
    step();
    n_vec++; if (take_action !== 4'h0 || take_no_action !== 4'h0 || jdo !== ow[3]) begin n_err++; $display("FAIL ready_empty act=%b nact=%b jdo=%h exp 0/0/%h", take_action, take_no_action, jdo, ow[3]); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_err_clr_and_full_pop();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL err_clr ovf=%b exp 0", overflow); end
    for (int k = 0; k < 4; k++) push_word(2'd1, 38'h00_0000_0100 + 38'(k));
    ir_in = 2'd0; sr = 38'h00_DEAD_0000; tog = ~tog; udr_toggle = tog;
    repeat (3) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_vec++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin n_err++; $display("FAIL set_wins ovf=%b level=%0d exp 1/4", overflow, fifo_level); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    ir_in = 2'd3; sr = 38'h08_CAFE_0001; tog = ~tog; udr_toggle = tog;
    repeat (3) step();
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    n_vec++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL full_pop level=%0d ovf=%b exp 4/0", fifo_level, overflow); end
    n_vec++; if (jdo !== 38'h00_0000_0100 || take_no_action !== 4'b0010 || take_action !== 4'b0000) begin n_err++; $display("FAIL full_pop_out jdo=%h nact=%b act=%b exp 100/0010/0000", jdo, take_no_action, take_action); end
    cmd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      n_vec++; if (jdo !== 38'h00_0000_0100 + 38'(i)) begin n_err++; $display("FAIL wrap_%0d jdo=%h exp %h", i, jdo, 38'h00_0000_0100 + 38'(i)); end
    end
    step();
    n_vec++; if (jdo !== 38'h08_CAFE_0001 || take_action !== 4'b1000 || fifo_level !== 3'd0) begin n_err++; $display("FAIL wrap_last jdo=%h act=%b level=%0d exp 8cafe0001/1000/0", jdo, take_action, fifo_level); end
    cmd_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    push_word(2'd1, 38'h08_0000_0055);
    push_word(2'd2, 38'h00_0000_0066);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    n_vec++; if (take_action !== 4'b0010) begin n_err++; $display("FAIL mid_pulse act=%b exp 0010", take_action); end
    reset = 1'b1; #1;
    n_vec++; if (take_action !== 4'h0 || fifo_level !== 3'd0 || cmd_valid !== 1'b0 || jdo !== 38'h0) begin n_err++; $display("FAIL mid_reset act=%b level=%0d valid=%b jdo=%h exp 0", take_action, fifo_level, cmd_valid, jdo); end
    step(); reset = 1'b0;
    repeat (6) step();
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_rearm level=%0d exp 0", fifo_level); end
    push_word(2'd3, 38'h00_0000_0077);
    n_vec++; if (fifo_level !== 3'd1 || head_ir !== 2'd3) begin n_err++; $display("FAIL mid_repush level=%0d hir=%0d exp 1/3", fifo_level, head_ir); end
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    n_vec++; if (take_no_action !== 4'b1000 || jdo !== 38'h00_0000_0077) begin n_err++; $display("FAIL mid_pop nact=%b jdo=%h exp 1000/77", take_no_action, jdo); end
  endtask

  task automatic test_parity();
`ifdef DBG_CMD_PARITY_EN
    push_word(2'd0, 38'h00_0000_0001);
    n_vec++; if (fifo_level !== 3'd0 || parity_err !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL parity_bad level=%0d perr=%b ovf=%b exp 0/1/0", fifo_level, parity_err, overflow); end
    push_word(2'd0, 38'h00_0000_0003);
    n_vec++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL parity_good level=%0d exp 1", fifo_level); end
`else
    push_word(2'd0, 38'h00_0000_0001);
    n_vec++; if (fifo_level !== 3'd1 || parity_err !== 1'b0) begin n_err++; $display("FAIL parity_off level=%0d perr=%b exp 1/0", fifo_level, parity_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow_drain();
    test_err_clr_and_full_pop();
    test_reset_mid();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
